// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file and neighbouring datapath blocks.
// Holds the clear-FSM state encoding and the default datapath widths.
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

    function automatic int rf_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/rf_multiport_if.sv
// Write/read bus of the multiport register file: two write ports, two asynchronous read ports.
// The master side issues writes and read addresses; the slave side is the register file.
interface rf_multiport_if
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
);

    logic              init_busy;
    logic              we0;
    logic [ADDR_W-1:0] wa0;
    logic [DATA_W-1:0] wd0;
    logic              we1;
    logic [ADDR_W-1:0] wa1;
    logic [DATA_W-1:0] wd1;
    logic [ADDR_W-1:0] ra0;
    logic [DATA_W-1:0] rd0;
    logic [ADDR_W-1:0] ra1;
    logic [DATA_W-1:0] rd1;

    modport master (
        input  init_busy,
        output we0, wa0, wd0,
        output we1, wa1, wd1,
        output ra0, ra1,
        input  rd0, rd1
    );

    modport slave (
        output init_busy,
        input  we0, wa0, wd0,
        input  we1, wa1, wd1,
        input  ra0, ra1,
        output rd0, rd1
    );

endinterface

// File: rtl/rf_read_port.sv
// One combinational read port: stored-word mux, zero-register masking,
// same-cycle write bypass (port 1 over port 0) and masking while the clear runs.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int DEPTH   = rf_depth(ADDR_W)
) (
    input  logic              init_busy,
    input  logic [DATA_W-1:0] mem [DEPTH],
    input  logic [ADDR_W-1:0] ra,
    // Enables arrive already qualified, so discarded writes are never forwarded.
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    output logic [DATA_W-1:0] rd
);

    logic hit0;
    logic hit1;

    assign hit0 = (BYPASS != 0) && we0 && (wa0 == ra);
    assign hit1 = (BYPASS != 0) && we1 && (wa1 == ra);

    always_comb begin
        rd = '0;
        if (init_busy) begin
            rd = '0;
        end else if ((ZERO_REG != 0) && (ra == '0)) begin
            rd = '0;
        end else if (hit1) begin
            rd = wd1;
        end else if (hit0) begin
            rd = wd0;
        end else begin
            rd = mem[ra];
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// Two-write / two-read register file with collision priority to write port 1,
// optional bypass and zero register, and a sequential clear engine after reset.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          clk,
    input  logic          reset,
    rf_multiport_if.slave bus
);

    localparam int DEPTH = rf_depth(ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_reg;
    rf_state_e         state_next;
    logic [ADDR_W-1:0] clr_idx_reg;
    logic [ADDR_W-1:0] clr_idx_next;
    logic              init_busy;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              we_eff [2];
    logic [ADDR_W-1:0] wa     [2];
    logic [DATA_W-1:0] wd     [2];
    logic [ADDR_W-1:0] ra     [2];
    logic [DATA_W-1:0] rd     [2];

    // ---------------- clear engine ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= RF_CLEAR;
            clr_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_idx_reg <= clr_idx_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_idx_next = clr_idx_reg;
        case (state_reg)
            RF_CLEAR: begin
                clr_idx_next = clr_idx_reg + 1'b1;
                if (clr_idx_reg == LAST_IDX) begin
                    state_next = RF_READY;
                end
            end
            RF_READY: begin
                state_next = RF_READY;
            end
            default: begin
                state_next   = RF_CLEAR;
                clr_idx_next = '0;
            end
        endcase
    end

    assign init_busy     = (state_reg == RF_CLEAR);
    assign bus.init_busy = init_busy;

    // ---------------- write qualification ----------------
    assign wa[0] = bus.wa0;
    assign wd[0] = bus.wd0;
    assign wa[1] = bus.wa1;
    assign wd[1] = bus.wd1;
    assign ra[0] = bus.ra0;
    assign ra[1] = bus.ra1;
    assign bus.rd0 = rd[0];
    assign bus.rd1 = rd[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_wq
            logic we_raw;
            assign we_raw = (gi == 0) ? bus.we0 : bus.we1;
            // Writes are dropped during clear and, with a zero register, to entry 0.
            assign we_eff[gi] = we_raw && !init_busy
                                && !((ZERO_REG != 0) && (wa[gi] == '0));
        end
    endgenerate

    // ---------------- storage ----------------
    // Port 1 is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (init_busy) begin
                mem[clr_idx_reg] <= '0;
            end else begin
                if (we_eff[0]) begin
                    mem[wa[0]] <= wd[0];
                end
                if (we_eff[1]) begin
                    mem[wa[1]] <= wd[1];
                end
            end
        end
    end

    // ---------------- read ports ----------------
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rd
            rf_read_port #(
                .DATA_W   (DATA_W),
                .ADDR_W   (ADDR_W),
                .ZERO_REG (ZERO_REG),
                .BYPASS   (BYPASS)
            ) u_read_port (
                .init_busy (init_busy),
                .mem       (mem),
                .ra        (ra[gi]),
                .we0       (we_eff[0]),
                .wa0       (wa[0]),
                .wd0       (wd[0]),
                .we1       (we_eff[1]),
                .wa1       (wa[1]),
                .wd1       (wd[1]),
                .rd        (rd[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_rf_multiport.sv
// Scoreboard bench for rf_multiport: a bypassing and a non-bypassing instance share
// stimulus; an array model predicts every read and init_busy each cycle.
module tb_rf_multiport;
    import rf_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    typedef struct {
        logic          busy;
        logic [DW-1:0] b0;
        logic [DW-1:0] b1;
        logic [DW-1:0] n0;
        logic [DW-1:0] n1;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rf_multiport_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
    rf_multiport_if #(.DATA_W(DW), .ADDR_W(AW)) bus_n ();

    assign bus_n.we0 = bus_b.we0;
    assign bus_n.wa0 = bus_b.wa0;
    assign bus_n.wd0 = bus_b.wd0;
    assign bus_n.we1 = bus_b.we1;
    assign bus_n.wa1 = bus_b.wa1;
    assign bus_n.wd1 = bus_b.wd1;
    assign bus_n.ra0 = bus_b.ra0;
    assign bus_n.ra1 = bus_b.ra1;

    rf_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    rf_multiport #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) dut_n (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n.slave)
    );

    // Reference model: plain array, count of clear cycles left, contents zeroed on reset.
    logic [DW-1:0] m_mem [DEPTH];
    int            busy_cnt    = 0;
    bit            model_valid = 1'b0;
    exp_t          q [$];
    int            vectors = 0;
    int            fails   = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra, input bit byp,
                                             input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                             input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        if (busy_cnt > 0) return '0;
        if (ra == 0) return '0;
        if (byp && w1 && a1 == ra) return d1;
        if (byp && w0 && a0 == ra) return d0;
        return m_mem[ra];
    endfunction

    task automatic cyc(input logic rst,
                       input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        exp_t e;
        reset     = rst;
        bus_b.we0 = w0;
        bus_b.wa0 = a0;
        bus_b.wd0 = d0;
        bus_b.we1 = w1;
        bus_b.wa1 = a1;
        bus_b.wd1 = d1;
        bus_b.ra0 = r0;
        bus_b.ra1 = r1;
        if (model_valid) begin
            e.busy = (busy_cnt > 0);
            e.b0   = exp_rd(r0, 1'b1, w0, a0, d0, w1, a1, d1);
            e.b1   = exp_rd(r1, 1'b1, w0, a0, d0, w1, a1, d1);
            e.n0   = exp_rd(r0, 1'b0, w0, a0, d0, w1, a1, d1);
            e.n1   = exp_rd(r1, 1'b0, w0, a0, d0, w1, a1, d1);
            q.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            model_valid = 1'b1;
            busy_cnt    = DEPTH;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (model_valid) begin
            if (busy_cnt > 0) begin
                busy_cnt--;
            end else begin
                if (w0 && a0 != 0) m_mem[a0] = d0;
                if (w1 && a1 != 0) m_mem[a1] = d1;
            end
        end
        #1;
    endtask

    task automatic idle(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        cyc(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, r0, r1);
    endtask

    // Monitor: outputs are combinational, so every cycle presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0) begin
            e = q.pop_front();
            chk("busy_byp",   {31'b0, bus_b.init_busy}, {31'b0, e.busy});
            chk("busy_nobyp", {31'b0, bus_n.init_busy}, {31'b0, e.busy});
            chk("rd0_byp",    bus_b.rd0, e.b0);
            chk("rd1_byp",    bus_b.rd1, e.b1);
            chk("rd0_nobyp",  bus_n.rd0, e.n0);
            chk("rd1_nobyp",  bus_n.rd1, e.n1);
        end
    end

    initial begin
        int            n;
        logic          rr, w0, w1;
        logic [AW-1:0] a0, a1, r0, r1;

        reset     = 1'b0;
        bus_b.we0 = 1'b0; bus_b.wa0 = '0; bus_b.wd0 = '0;
        bus_b.we1 = 1'b0; bus_b.wa1 = '0; bus_b.wd1 = '0;
        bus_b.ra0 = '0;   bus_b.ra1 = '0;
        repeat (2) @(posedge clk);
        #1;

        // Clear timing after a single reset cycle.
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
        n = 0;
        while (bus_b.init_busy === 1'b1 && n < 100) begin
            idle(AW'(n), AW'(31 - n));
            n++;
        end
        chk("clear_cycles", DW'(n), 32);
        for (int i = 0; i < DEPTH; i++) idle(AW'(i), AW'(DEPTH - 1 - i));

        // Seed some data, then reset mid-clear at clr_idx 10 with writes pulsed during clear.
        cyc(1'b0, 1'b1, 5'd5, 32'h0BAD_0005, 1'b1, 5'd9, 32'h0BAD_0009, 5'd5, 5'd9);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd5, 5'd9);
        repeat (10) idle(5'd5, 5'd9);
        cyc(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 5'd5, 5'd9);
        n = 0;
        while (bus_b.init_busy === 1'b1 && n < 100) begin
            cyc(1'b0, 1'b0, '0, '0, (n % 4) == 0, 5'd5, 32'hFFFF_FFFF, 5'd5, 5'd5);
            n++;
        end
        chk("restart_cycles", DW'(n), 32);
        idle(5'd5, 5'd9);

        // Collision: port 1 wins.
        cyc(1'b0, 1'b1, 5'd7, 32'hAAAA_0000, 1'b1, 5'd7, 32'h5555_FFFF, 5'd7, 5'd7);
        idle(5'd7, 5'd7);

        // Zero register: write discarded, never bypassed.
        cyc(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, '0, '0, 5'd0, 5'd0);
        idle(5'd0, 5'd0);
        cyc(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'hCAFE_F00D, 5'd0, 5'd0);
        idle(5'd0, 5'd0);

        // Bypass vs. registered visibility.
        cyc(1'b0, 1'b1, 5'd3, 32'h1234_5678, 1'b0, '0, '0, 5'd0, 5'd3);
        idle(5'd0, 5'd3);
        cyc(1'b0, 1'b1, 5'd3, 32'h0000_1111, 1'b1, 5'd4, 32'h0000_2222, 5'd4, 5'd3);
        idle(5'd4, 5'd3);

        // Randomised traffic with occasional resets; narrow address range forces collisions.
        for (int k = 0; k < 800; k++) begin
            rr = ($urandom_range(0, 299) == 0);
            w0 = $urandom_range(0, 1) == 1;
            w1 = $urandom_range(0, 1) == 1;
            a0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
            r0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, 31));
            r1 = ($urandom_range(0, 2) == 0) ? a1 : AW'($urandom_range(0, 31));
            cyc(rr, w0, a0, DW'($urandom), w1, a1, DW'($urandom), r0, r1);
        end
        n = 0;
        while (bus_b.init_busy === 1'b1 && n < 40) begin
            idle('0, '0);
            n++;
        end
        for (int i = 0; i < DEPTH; i++) idle(AW'(i), AW'(i ^ 1));

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/rf_multiport.md
Name: rf_multiport

Overview:
- Parametrised register file that succeeds the single-write CPU register file in the CA datapath.
- Provides two asynchronous read ports and two write ports with defined collision priority.
- Offers optional write-to-read bypass and an optional hardwired zero register.
- Clears every entry to zero through a sequential clear engine after reset; downstream control stalls on init_busy until the clear completes.

Parameters:
- DATA_W, 32, width of each register and data port.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- ZERO_REG, 1, 1 = entry 0 reads 0 and writes to it are discarded.
- BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read port.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; restarts the clear sequence.
- init_busy  output  1  high while the clear engine runs; writes are ignored while high.
- we0  input  1  write enable, port 0.
- wa0  input  ADDR_W  write address, port 0.
- wd0  input  DATA_W  write data, port 0.
- we1  input  1  write enable, port 1 (higher priority).
- wa1  input  ADDR_W  write address, port 1.
- wd1  input  DATA_W  write data, port 1.
- ra0  input  ADDR_W  read address A.
- rd0  output  DATA_W  read data A, combinational.
- ra1  input  ADDR_W  read address B.
- rd1  output  DATA_W  read data B, combinational.

Behaviour:
- Interface: one clock (clk). reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- FSM states: CLEAR, READY.
  - reset=1 at an edge -> state=CLEAR, clr_idx=0. No entry is written on that edge.
  - CLEAR: each edge writes 0 to entry clr_idx, then clr_idx increments.
  - At the edge where clr_idx == DEPTH-1, the state moves to READY.
  - The clear takes exactly DEPTH cycles after reset deasserts.
- init_busy is 1 in CLEAR and 0 in READY. It is 1 in the cycle after any reset edge.
- Reset mid-clear: clr_idx returns to 0 and the full sequence restarts.
- Reset while READY: the design re-enters CLEAR.
- Contents before the first reset are undefined.
- While in CLEAR:
  - we0 and we1 are ignored and no user write lands.
  - rd0 and rd1 read 0 regardless of address.
- Writes in READY take effect at the rising edge and are visible to non-bypassed reads from the next cycle.
- Write collision (we0 & we1 & wa0==wa1): wd1 is stored and wd0 is dropped.
- Distinct write addresses: both writes land on the same edge.
- ZERO_REG=1:
  - A read of address 0 returns 0.
  - A write to address 0 on either port is discarded.
  - A discarded write is never bypassed.
- BYPASS=1 (READY only): for each read port, evaluate in this order:
  - if we1 & wa1==ra, rd = wd1;
  - else if we0 & wa0==ra, rd = wd0;
  - else rd = stored entry.
- BYPASS=0: a read returns the stored value only. New data is visible the cycle after the write.
- Each read port is independent; both ports may read the same address.
- Address width equals log2(DEPTH), so no address is out of range.
- Data is passed unmodified: no arithmetic, no sign extension.

Decomposition:
- Shared package/header rf_pkg holds:
  - FSM state encodings RF_CLEAR=1'b0 and RF_READY=1'b1;
  - default DATA_W and ADDR_W constants shared with datapath modules.
- One natural sub-module, rf_read_port, implemented once and instantiated twice for rd0 and rd1. It contains:
  - read mux;
  - zero-register masking;
  - bypass compare/priority logic;
  - init_busy masking.
- The storage array, write arbitration and clear FSM stay in the top module.

Test Plan:
1. Clear timing: assert reset for 1 cycle, then deassert -> init_busy=1 for exactly 32 cycles then 0. Afterwards ra0=0..31 each reads 32'h0.
2. Reset mid-clear: assert reset again when clr_idx=10 -> init_busy stays 1 for another full 32 cycles.
3. Collision priority: we0=we1=1, wa0=wa1=7, wd0=32'hAAAA_0000, wd1=32'h5555_FFFF. Next cycle ra0=7 -> rd0=32'h5555_FFFF.
4. Zero register: write 32'hDEAD_BEEF to address 0 on port 0 -> rd0 at ra0=0 is 0, both in the write cycle and in the next cycle.
5. Bypass: BYPASS=1, we0=1, wa0=3, wd0=32'h1234_5678, ra1=3 -> rd1=32'h1234_5678 in the same cycle. With BYPASS=0, rd1 shows the old value that cycle and the new value the next cycle.
6. Writes during clear: we1=1, wa1=5, wd1=32'hFFFF_FFFF pulsed while init_busy=1 -> entry 5 reads 0 after the clear completes.
